ysyx_22040383_mdu_ctrl: RTL and testbench

- Multi-cycle multiply/divide sequencer for the EX stage, replacing single-cycle mul/div/rem with an iterative engine.
- Sequences a 64-iteration shift-add multiply and a shift-subtract restoring divide.
- Exposes valid/ready handshakes to the decode/EX pipeline, and a busy flag that the hazard unit uses to stall issue.
- Flushable by the pipeline on redirect.

---
 rtl/ysyx_22040383_mdu_ctrl_pkg.sv | 25 ++
 rtl/ysyx_22040383_div_step.sv | 26 ++
 rtl/ysyx_22040383_mdu_ctrl.sv | 156 +++++++++++++++
 tb/tb_ysyx_22040383_mdu_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040383_mdu_ctrl_pkg.sv
// Shared definitions for the multi-cycle multiply/divide sequencer:
// op encodings, sequencer states and default widths.
package ysyx_22040383_mdu_ctrl_pkg;

   localparam int MDU_XLEN  = 64;
   localparam int MDU_CNT_W = 7;

   localparam logic [2:0] ysyx_22040383_mdu_mul  = 3'b000;
   localparam logic [2:0] ysyx_22040383_mdu_div  = 3'b100;
   localparam logic [2:0] ysyx_22040383_mdu_divu = 3'b101;
   localparam logic [2:0] ysyx_22040383_mdu_rem  = 3'b110;
   localparam logic [2:0] ysyx_22040383_mdu_remu = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } mdu_state_e;

   // Every code with bit 2 set is a divide/remainder; MUL is the only other legal code.
   function automatic logic op_legal(input logic [2:0] op);
      return (op == ysyx_22040383_mdu_mul) || op[2];
   endfunction

endpackage

// File: rtl/ysyx_22040383_div_step.sv
// One combinational restoring-division iteration: shift one dividend bit into
// the partial remainder, subtract the divisor if it fits, and record the quotient bit.
module ysyx_22040383_div_step #(
   parameter int XLEN = 64
) (
   input  logic [XLEN-1:0] rem,
   input  logic [XLEN-1:0] quo,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] rem_next,
   output logic [XLEN-1:0] quo_next
);

   logic [XLEN:0] shifted;
   logic [XLEN:0] diff;
   logic          fits;

   // The remainder stays below the divisor, so the borrow bit alone tells whether it fits.
   always_comb begin
      shifted  = {rem, quo[XLEN-1]};
      diff     = shifted - {1'b0, divisor};
      fits     = ~diff[XLEN];
      rem_next = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
      quo_next = {quo[XLEN-2:0], fits};
   end

endmodule

// File: rtl/ysyx_22040383_mdu_ctrl.sv
// Iterative multiply/divide sequencer for the EX stage (IDLE -> CALC -> DONE).
// Optional macro YSYX_22040383_MDU_EARLY_OUT_EN: finish trivial operations at accept.
module ysyx_22040383_mdu_ctrl
   import ysyx_22040383_mdu_ctrl_pkg::*;
#(
   parameter int XLEN  = MDU_XLEN,
   parameter int CNT_W = MDU_CNT_W
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      in_op,
   input  logic [XLEN-1:0] in_a,
   input  logic [XLEN-1:0] in_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_res,
   output logic            busy
);

   mdu_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [XLEN-1:0]  x_q, y_q, acc_q, res_q;
   logic             is_div_q, is_rem_q, q_neg_q, r_neg_q;

   logic             accept, in_legal, in_is_div, in_signed, a_neg, b_neg;
   logic [XLEN-1:0]  a_mag, b_mag;
   logic [XLEN-1:0]  mul_acc_next, rem_nx, quo_nx, final_res;
   logic             early_hit;
   logic [XLEN-1:0]  early_res;

   assign in_ready  = (state_q == IDLE) & ~flush;
   assign accept    = in_valid & in_ready;
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign out_res   = res_q;

   // Signed divides run on magnitudes; the signs are reapplied when the result is formed.
   always_comb begin
      in_legal  = op_legal(in_op);
      in_is_div = in_op[2];
      in_signed = in_is_div & ~in_op[0];
      a_neg     = in_signed & in_a[XLEN-1];
      b_neg     = in_signed & in_b[XLEN-1];
      a_mag     = a_neg ? -in_a : in_a;
      b_mag     = b_neg ? -in_b : in_b;
   end

`ifdef YSYX_22040383_MDU_EARLY_OUT_EN
   logic div_zero, sgn_ovf, mul_zero;

   always_comb begin
      div_zero  = in_is_div & (in_b == '0);
      sgn_ovf   = in_signed & (in_a == {1'b1, {(XLEN-1){1'b0}}}) & (in_b == '1);
      mul_zero  = ~in_is_div & ((in_a == '0) | (in_b == '0));
      early_hit = in_legal & (div_zero | sgn_ovf | mul_zero);
      early_res = '0;
      if (div_zero)
         early_res = in_op[1] ? in_a : '1;
      else if (sgn_ovf)
         early_res = in_op[1] ? '0 : in_a;
   end
`else
   assign early_hit = 1'b0;
   assign early_res = '0;
`endif

   ysyx_22040383_div_step #(.XLEN(XLEN)) u_div_step (
      .rem      (acc_q),
      .quo      (x_q),
      .divisor  (y_q),
      .rem_next (rem_nx),
      .quo_next (quo_nx)
   );

   always_comb begin
      mul_acc_next = acc_q + (y_q[0] ? x_q : '0);
      if (!is_div_q)
         final_res = mul_acc_next;
      else if (is_rem_q)
         final_res = r_neg_q ? -rem_nx : rem_nx;
      else
         final_res = q_neg_q ? -quo_nx : quo_nx;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (accept) state_d = (!in_legal || early_hit) ? DONE : CALC;
         CALC: if (cnt_q == CNT_W'(1)) state_d = DONE;
         DONE: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (flush)
         state_d = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // MUL: x = shifted multiplicand, y = multiplier, acc = sum.
   // DIV: x = dividend/quotient shift register, y = divisor, acc = partial remainder.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         x_q      <= '0;
         y_q      <= '0;
         acc_q    <= '0;
         res_q    <= '0;
         is_div_q <= 1'b0;
         is_rem_q <= 1'b0;
         q_neg_q  <= 1'b0;
         r_neg_q  <= 1'b0;
      end else if (flush) begin
         cnt_q <= '0;
      end else begin
         case (state_q)
            IDLE: if (accept) begin
               cnt_q    <= CNT_W'(XLEN);
               x_q      <= a_mag;
               y_q      <= b_mag;
               acc_q    <= '0;
               is_div_q <= in_is_div;
               is_rem_q <= in_is_div & in_op[1];
               q_neg_q  <= (a_neg ^ b_neg) & (in_b != '0);
               r_neg_q  <= a_neg;
               if (!in_legal)
                  res_q <= '0;
               else if (early_hit)
                  res_q <= early_res;
            end
            CALC: begin
               cnt_q <= cnt_q - CNT_W'(1);
               if (is_div_q) begin
                  acc_q <= rem_nx;
                  x_q   <= quo_nx;
               end else begin
                  acc_q <= mul_acc_next;
                  x_q   <= x_q << 1;
                  y_q   <= y_q >> 1;
               end
               if (cnt_q == CNT_W'(1))
                  res_q <= final_res;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_22040383_mdu_ctrl.sv
// Scoreboard bench for ysyx_22040383_mdu_ctrl: directed ops push expected results,
// a monitor checks latency and value at each output handshake.
module tb_ysyx_22040383_mdu_ctrl;

   localparam logic [2:0] OP_MUL  = 3'b000;
   localparam logic [2:0] OP_DIV  = 3'b100;
   localparam logic [2:0] OP_DIVU = 3'b101;
   localparam logic [2:0] OP_REM  = 3'b110;
   localparam logic [2:0] OP_REMU = 3'b111;
   localparam int         LAT_FULL = 65;

   typedef struct {
      logic [63:0] res;
      int          lat;
      int          acc;
      string       name;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, busy;
   logic [2:0]  in_op;
   logic [63:0] in_a, in_b, out_res;

   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   exp_t exp_q[$];
   bit   head_seen = 0;
   int   lat_early;
   int   acc1, acc2, dummy;

   ysyx_22040383_mdu_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_res   (out_res),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: first valid cycle of the head checks latency, the handshake checks the value.
   always @(negedge clk) begin
      if (!rst_n) begin
         head_seen = 0;
      end else if (out_valid) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL spurious_valid: got out_res=%h want no output", out_res);
         end else begin
            if (!head_seen) begin
               head_seen = 1;
               total++;
               if (cyc - exp_q[0].acc + 1 != exp_q[0].lat) begin
                  bad++;
                  $display("[TB] FAIL %s_latency: got %0d want %0d", exp_q[0].name,
                           cyc - exp_q[0].acc + 1, exp_q[0].lat);
               end
            end
            if (out_ready && !flush) begin
               total++;
               if (out_res !== exp_q[0].res) begin
                  bad++;
                  $display("[TB] FAIL %s_result: got %h want %h", exp_q[0].name,
                           out_res, exp_q[0].res);
               end
               void'(exp_q.pop_front());
               head_seen = 0;
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %h want %h", name, actual, expected);
      end
   endtask

   // Called just after a rising edge; returns just after the accept edge.
   task automatic applyStimulus(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                                input logic [63:0] res, input int lat, input bit track,
                                input string name, output int acc_edge);
      int waited = 0;
      in_valid = 1'b1;
      in_op    = op;
      in_a     = a;
      in_b     = b;
      acc_edge = -1;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         waited++;
         if (waited > 300) break;
      end
      if (!in_ready) begin
         total++;
         bad++;
         $display("[TB] FAIL %s_accept: got no accept want accept within 300 cycles", name);
         in_valid = 1'b0;
      end else begin
         acc_edge = cyc + 1;
         if (track) exp_q.push_back('{res, lat, acc_edge, name});
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         in_a     = {$urandom, $urandom};
         in_b     = {$urandom, $urandom};
      end
   endtask

   task automatic waitIdle();
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(posedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("[TB] FAIL drain_timeout: got %0d pending want 0", exp_q.size());
         exp_q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic runOp(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] res, input int lat, input string name);
      int acc;
      applyStimulus(op, a, b, res, lat, 1'b1, name, acc);
      waitIdle();
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got hang want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
`ifdef YSYX_22040383_MDU_EARLY_OUT_EN
      lat_early = 1;
`else
      lat_early = LAT_FULL;
`endif
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = '0;
      in_a = '0; in_b = '0; out_ready = 1'b1;
      #3;
      checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
      checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
      checkOutput("reset_busy", 64'(busy), 64'd0);
      checkOutput("reset_out_res", out_res, 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      $display("[TB] MUL 7*6 with consumer stalled for 3 cycles");
      out_ready = 1'b0;
      applyStimulus(OP_MUL, 64'd7, 64'd6, 64'h2A, LAT_FULL, 1'b1, "mul_7x6", dummy);
      for (int n = 0; n < 100 && !out_valid; n++) @(negedge clk);
      checkOutput("hold_valid_seen", 64'(out_valid), 64'd1);
      for (int i = 0; i < 3; i++) begin
         if (i > 0) @(negedge clk);
         checkOutput("hold_res", out_res, 64'h2A);
         checkOutput("hold_busy", 64'(busy), 64'd1);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      waitIdle();

      $display("[TB] divide vectors");
      runOp(OP_DIV,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, LAT_FULL, "div_m7_2");
      runOp(OP_REM,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, LAT_FULL, "rem_m7_2");
      runOp(OP_REMU, 64'd100, 64'd7, 64'd2, LAT_FULL, "remu_100_7");
      runOp(OP_DIVU, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'h0FFF_FFFF_FFFF_FFFF, LAT_FULL, "divu_big");
      runOp(OP_REMU, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'hF, LAT_FULL, "remu_big");
      runOp(OP_MUL,  64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, LAT_FULL, "mul_wrap");

      $display("[TB] divide by zero, overflow, zero multiply, illegal op");
      runOp(OP_DIVU, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, lat_early, "divu_by0");
      runOp(OP_REM,  64'd5, 64'd0, 64'd5, lat_early, "rem_by0");
      runOp(OP_DIV,  64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, lat_early, "div_m5_by0");
      runOp(OP_REM,  64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, lat_early, "rem_m5_by0");
      runOp(OP_DIV,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
            64'h8000_0000_0000_0000, lat_early, "div_ovf");
      runOp(OP_REM,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, lat_early, "rem_ovf");
      runOp(OP_MUL,  64'd0, 64'd5, 64'd0, lat_early, "mul_zero");
      runOp(3'b011,  64'd5, 64'd5, 64'd0, 1, "illegal_op");

      $display("[TB] flush at CALC cycle 30");
      applyStimulus(OP_DIV, 64'd1000, 64'd3, 64'd0, 0, 1'b0, "div_flushed", dummy);
      repeat (29) @(posedge clk);
      #1;
      flush = 1'b1;
      @(negedge clk);
      checkOutput("flush_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      flush = 1'b0;
      checkOutput("flush_busy", 64'(busy), 64'd0);
      checkOutput("flush_out_valid", 64'(out_valid), 64'd0);
      repeat (70) @(posedge clk);
      #1;
      runOp(OP_MUL, 64'd3, 64'd3, 64'd9, LAT_FULL, "mul_after_flush");

      $display("[TB] request during flush");
      flush = 1'b1; in_valid = 1'b1; in_op = OP_MUL; in_a = 64'd2; in_b = 64'd2;
      @(negedge clk);
      checkOutput("flushvalid_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0;
      checkOutput("flushvalid_no_accept", 64'(busy), 64'd0);
      @(posedge clk); #1;

      $display("[TB] back-to-back requests");
      applyStimulus(OP_DIVU, 64'd100, 64'd7, 64'd14, LAT_FULL, 1'b1, "b2b_first", acc1);
      applyStimulus(OP_MUL, 64'd5, 64'd5, 64'd25, LAT_FULL, 1'b1, "b2b_second", acc2);
      checkOutput("b2b_accept_edge", 64'(acc2), 64'(acc1 + LAT_FULL + 1));
      waitIdle();

      $display("[TB] asynchronous reset mid-CALC");
      applyStimulus(OP_MUL, 64'd9, 64'd9, 64'd0, 0, 1'b0, "mul_reset", dummy);
      repeat (10) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("rstmid_out_valid", 64'(out_valid), 64'd0);
      checkOutput("rstmid_busy", 64'(busy), 64'd0);
      checkOutput("rstmid_out_res", out_res, 64'd0);
      checkOutput("rstmid_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      runOp(OP_MUL, 64'd3, 64'd4, 64'd12, LAT_FULL, "mul_after_reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
